palette_ram_writer: RTL and testbench
=====================================

PALETTE_RAM_WRITER -- requirements
Module: palette_ram_writer

Interface
REQ-001 SHALL have a single clock domain: all state updates on rising edge of clk.
REQ-002 SHALL use an asynchronous, active-high reset on port rst.
REQ-003 Ports (name  direction  width  meaning):
  clk        in   1   clock
  rst        in   1   async active-high reset
  cpu_we     in   1   one-cycle register write strobe
  cpu_reg    in   1   0 = address register (PPUADDR), 1 = data register (PPUDATA)
  cpu_din    in   8   write data
  inc32      in   1   address step: 0 = +1, 1 = +32
  status_rd  in   1   one-cycle PPUSTATUS read; clears write toggle
  rd_addr    in   5   renderer palette index
  rd_dout    out  6   palette colour at rd_addr, combinational, same cycle
  vaddr      out  14  current VRAM address
  pal_wr_ack out  1   one-cycle pulse: palette entry written by CPU
  ext_wr     out  1   one-cycle pulse: data write outside palette space (for nametable/pattern logic)
  ready      out  1   high once post-reset clear is done
REQ-004 SHALL have no parameters; storage fixed at 32 x 6 bits.

Function
REQ-005 FSM states SHALL be CLEAR and IDLE; reset enters CLEAR.
REQ-006 In CLEAR, an internal 5-bit counter SHALL write 6'h0F to entry counter at each clock edge, counting 0..31.
REQ-007 On the edge writing entry 31, FSM SHALL go to IDLE and ready SHALL become 1 (32nd edge after rst falls).
REQ-008 In CLEAR, cpu_we and status_rd SHALL be ignored: no toggle change, no vaddr change, no pulses.
REQ-009 In IDLE, cpu_we=1, cpu_reg=0, toggle w=0 SHALL latch cpu_din[5:0] as tmp_hi and set w=1; cpu_din[7:6] discarded.
REQ-010 In IDLE, cpu_we=1, cpu_reg=0, w=1 SHALL load vaddr={tmp_hi,cpu_din} and clear w.
REQ-011 In IDLE, cpu_we=1, cpu_reg=1 SHALL perform a data write at current vaddr, then advance vaddr by 1 (inc32=0) or 32 (inc32=1), modulo 2^14; w unchanged.
REQ-012 Data write with vaddr[13:8]=6'h3F SHALL write cpu_din[5:0] to entry m(vaddr[4:0]) and pulse pal_wr_ack the following cycle; vaddr[7:5] ignored (mirroring).
REQ-013 Mirror map m(i): if i[1:0]=2'b00 then {1'b0,i[3:0]}, else i; entries 0x10/0x14/0x18/0x1C alias 0x00/0x04/0x08/0x0C.
REQ-014 Data write with vaddr[13:8]!=6'h3F SHALL leave palette unchanged and pulse ext_wr the following cycle.
REQ-015 rd_dout SHALL equal entry m(rd_addr), combinational; a same-cycle write becomes visible after the edge.
REQ-016 status_rd=1 SHALL clear w at the edge; with cpu_we=1 in the same cycle, the write SHALL be decoded with pre-clear w, and w SHALL end 0.
REQ-017 vaddr wrap: 14'h3FFF +1 -> 14'h0000; 14'h3FF0 +32 -> 14'h0010.
REQ-018 pal_wr_ack and ext_wr SHALL never both be 1 and SHALL each be high at most one cycle per write.

Reset
REQ-019 rst=1 SHALL immediately force: vaddr=0, tmp_hi=0, w=0, pal_wr_ack=0, ext_wr=0, ready=0, counter=0, FSM=CLEAR.
REQ-020 rst asserted mid-CLEAR or mid-IDLE SHALL restart the full 32-cycle clear; palette contents before clear completion are unspecified.

Verification
REQ-021 Release rst, idle 32 edges -> ready=1 at edge 32, rd_dout=6'h0F for all 32 rd_addr values.
REQ-022 Writes 0x3F,0x00 to addr reg, then data 0x31,0x1B,0x2B,0x37 (inc32=0) -> entries 0..3 = 31,1B,2B,37, vaddr=14'h3F04, four pal_wr_ack pulses.
REQ-023 Set vaddr=14'h3F10, write data 0x2A -> rd_addr 0x00 and 0x10 both return 6'h2A; vaddr=14'h3F11.
REQ-024 Set vaddr=14'h2000, inc32=1, write data 0x55 twice -> two ext_wr pulses, no pal_wr_ack, palette unchanged, vaddr=14'h2040.
REQ-025 Write 0x3F to addr reg, pulse status_rd, write 0x3F, 0x05 -> vaddr=14'h3F05 (first byte discarded by toggle clear); vaddr=14'h3FFF, data write -> vaddr=14'h0000, palette entry m(0x1F) written.
REQ-026 cpu_we pulses during CLEAR then rst mid-clear at cycle 10 -> vaddr stays 0, no pulses, ready rises 32 edges after second release.

Source files
------------

// File: rtl/palette_ram_writer_if.sv
// CPU-side register port and renderer read port of the palette RAM writer.
// The master side drives the CPU strobes and the renderer read index.
// The slave side is the writer itself.
interface palette_ram_writer_if;
    logic        cpu_we;
    logic        cpu_reg;
    logic [7:0]  cpu_din;
    logic        inc32;
    logic        status_rd;
    logic [4:0]  rd_addr;
    logic [5:0]  rd_dout;
    logic [13:0] vaddr;
    logic        pal_wr_ack;
    logic        ext_wr;
    logic        ready;

    modport master (
        output cpu_we, cpu_reg, cpu_din, inc32, status_rd, rd_addr,
        input  rd_dout, vaddr, pal_wr_ack, ext_wr, ready
    );

    modport slave (
        input  cpu_we, cpu_reg, cpu_din, inc32, status_rd, rd_addr,
        output rd_dout, vaddr, pal_wr_ack, ext_wr, ready
    );
endinterface

// File: rtl/palette_ram_writer.sv
// Palette RAM writer: PPUADDR/PPUDATA style register pair feeding a
// 32 x 6-bit palette with the hardware mirroring of the four backdrop
// entries (0x10/0x14/0x18/0x1C fold onto 0x00/0x04/0x08/0x0C).
// After reset the palette is filled with 6'h0F over 32 cycles before
// CPU accesses are honoured.
module palette_ram_writer (
    input  logic                 clk,
    input  logic                 rst,
    palette_ram_writer_if.slave  bus
);
    typedef enum logic {CLEAR, IDLE} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_clr_cnt;
    logic [5:0]  r_pal [32];
    logic [13:0] r_vaddr;
    logic [5:0]  r_tmp_hi;
    logic        r_w;
    logic        r_pal_ack;
    logic        r_ext_wr;

    logic        w_idle;
    logic        w_addr_wr;
    logic        w_data_wr;
    logic        w_pal_hit;
    logic [13:0] w_step;

    // Backdrop mirroring: entries with index[1:0]==0 share the lower half.
    function automatic logic [4:0] f_mirror(input logic [4:0] i);
        return (i[1:0] == 2'b00) ? {1'b0, i[3:0]} : i;
    endfunction

    assign w_idle    = (r_state == IDLE);
    assign w_addr_wr = w_idle && bus.cpu_we && !bus.cpu_reg;
    assign w_data_wr = w_idle && bus.cpu_we &&  bus.cpu_reg;
    assign w_pal_hit = (r_vaddr[13:8] == 6'h3F);
    assign w_step    = bus.inc32 ? 14'd32 : 14'd1;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= CLEAR;
        else     r_state <= w_state_nxt;
    end

    // Next state: leave CLEAR on the edge that writes the last entry.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CLEAR:   if (r_clr_cnt == 5'd31) w_state_nxt = IDLE;
            IDLE:    w_state_nxt = IDLE;
            default: w_state_nxt = CLEAR;
        endcase
    end

    // Clear counter; it wraps back to 0 as the FSM reaches IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  r_clr_cnt <= 5'd0;
        else if (r_state == CLEAR) r_clr_cnt <= r_clr_cnt + 5'd1;
    end

    // Palette storage: clear fill, then CPU data writes into palette space.
    // Contents are left unreset; the clear pass defines them.
    always_ff @(posedge clk) begin
        if (r_state == CLEAR)
            r_pal[r_clr_cnt] <= 6'h0F;
        else if (w_data_wr && w_pal_hit)
            r_pal[f_mirror(r_vaddr[4:0])] <= bus.cpu_din[5:0];
    end

    // Address register, write toggle and write pulses. The toggle is
    // decoded before the status-read clear so a same-cycle write sees
    // the old value, and the clear still wins for the final state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vaddr   <= 14'd0;
            r_tmp_hi  <= 6'd0;
            r_w       <= 1'b0;
            r_pal_ack <= 1'b0;
            r_ext_wr  <= 1'b0;
        end else begin
            r_pal_ack <= w_data_wr &&  w_pal_hit;
            r_ext_wr  <= w_data_wr && !w_pal_hit;
            if (w_addr_wr) begin
                if (!r_w) begin
                    r_tmp_hi <= bus.cpu_din[5:0];
                    r_w      <= 1'b1;
                end else begin
                    r_vaddr  <= {r_tmp_hi, bus.cpu_din};
                    r_w      <= 1'b0;
                end
            end
            if (w_data_wr)
                r_vaddr <= r_vaddr + w_step;
            if (w_idle && bus.status_rd)
                r_w <= 1'b0;
        end
    end

    assign bus.rd_dout    = r_pal[f_mirror(bus.rd_addr)];
    assign bus.vaddr      = r_vaddr;
    assign bus.pal_wr_ack = r_pal_ack;
    assign bus.ext_wr     = r_ext_wr;
    assign bus.ready      = w_idle;
endmodule

// File: tb/tb_palette_ram_writer.sv
// Directed bench for palette_ram_writer: reset/clear sequencing by hand,
// then a table of one-cycle register accesses with expected results.
module tb_palette_ram_writer;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    palette_ram_writer_if bus ();

    palette_ram_writer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        rg;
        logic [7:0]  din;
        logic        i32;
        logic        st;
        logic [4:0]  ra;
        logic [13:0] e_va;
        logic        e_ack;
        logic        e_ext;
        logic [5:0]  e_rd;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic we, input logic rg, input logic [7:0] din,
                       input logic i32, input logic st, input logic [4:0] ra,
                       input logic [13:0] e_va, input logic e_ack, input logic e_ext,
                       input logic [5:0] e_rd);
        vec_t v;
        v.we = we; v.rg = rg; v.din = din; v.i32 = i32; v.st = st; v.ra = ra;
        v.e_va = e_va; v.e_ack = e_ack; v.e_ext = e_ext; v.e_rd = e_rd;
        vt.push_back(v);
    endtask

    task automatic drive_idle();
        bus.cpu_we = 1'b0; bus.cpu_reg = 1'b0; bus.cpu_din = 8'h00;
        bus.inc32 = 1'b0; bus.status_rd = 1'b0;
    endtask

    // Wait for ready after a reset release; returns the edge count it rose on.
    task automatic wait_ready(output int edges);
        edges = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (bus.ready === 1'b1) begin
                edges = k;
                break;
            end
        end
    endtask

    initial begin
        int edges;
        n_chk = 0;
        n_err = 0;
        bus.rd_addr = 5'd0;
        drive_idle();
        rst = 1'b1;

        // we, rg, din, i32, st, ra, e_va, ack, ext, rd
        add(1,0,8'h3F,0,0,5'h00,14'h0000,0,0,6'h0F);
        add(1,0,8'h00,0,0,5'h00,14'h3F00,0,0,6'h0F);
        add(1,1,8'h31,0,0,5'h00,14'h3F01,1,0,6'h31);
        add(1,1,8'h1B,0,0,5'h01,14'h3F02,1,0,6'h1B);
        add(1,1,8'h2B,0,0,5'h02,14'h3F03,1,0,6'h2B);
        add(1,1,8'h37,0,0,5'h03,14'h3F04,1,0,6'h37);
        add(0,0,8'h00,0,0,5'h04,14'h3F04,0,0,6'h0F);
        add(1,0,8'h3F,0,0,5'h00,14'h3F04,0,0,6'h31);
        add(1,0,8'h10,0,0,5'h00,14'h3F10,0,0,6'h31);
        add(1,1,8'h2A,0,0,5'h00,14'h3F11,1,0,6'h2A);
        add(0,0,8'h00,0,0,5'h10,14'h3F11,0,0,6'h2A);
        add(1,0,8'h20,0,0,5'h00,14'h3F11,0,0,6'h2A);
        add(1,0,8'h00,0,0,5'h00,14'h2000,0,0,6'h2A);
        add(1,1,8'h55,1,0,5'h00,14'h2020,0,1,6'h2A);
        add(1,1,8'h55,1,0,5'h15,14'h2040,0,1,6'h0F);
        add(0,0,8'h00,0,0,5'h01,14'h2040,0,0,6'h1B);
        add(1,0,8'h3F,0,0,5'h00,14'h2040,0,0,6'h2A);
        add(0,0,8'h00,0,1,5'h00,14'h2040,0,0,6'h2A);
        add(1,0,8'h3F,0,0,5'h00,14'h2040,0,0,6'h2A);
        add(1,0,8'h05,0,0,5'h00,14'h3F05,0,0,6'h2A);
        add(1,0,8'h3F,0,0,5'h00,14'h3F05,0,0,6'h2A);
        add(1,0,8'hFF,0,0,5'h00,14'h3FFF,0,0,6'h2A);
        add(1,1,8'h12,0,0,5'h1F,14'h0000,1,0,6'h12);
        add(0,0,8'h00,0,0,5'h1F,14'h0000,0,0,6'h12);
        add(1,0,8'h3F,0,1,5'h00,14'h0000,0,0,6'h2A);
        add(1,0,8'h21,0,0,5'h00,14'h0000,0,0,6'h2A);
        add(1,0,8'h34,0,0,5'h00,14'h2134,0,0,6'h2A);
        add(1,0,8'h3F,0,0,5'h00,14'h2134,0,0,6'h2A);
        add(1,0,8'h07,0,1,5'h00,14'h3F07,0,0,6'h2A);
        add(1,0,8'hFF,0,0,5'h00,14'h3F07,0,0,6'h2A);
        add(1,0,8'h08,0,0,5'h00,14'h3F08,0,0,6'h2A);
        add(1,0,8'h3F,0,0,5'h00,14'h3F08,0,0,6'h2A);
        add(1,0,8'hF0,0,0,5'h00,14'h3FF0,0,0,6'h2A);
        add(1,1,8'h09,1,0,5'h00,14'h0010,1,0,6'h09);

        // Reset values while rst is held.
        #3;
        chk("rst_vaddr", 32'(bus.vaddr), 32'h0);
        chk("rst_ready", 32'(bus.ready), 32'h0);
        chk("rst_ack",   32'(bus.pal_wr_ack), 32'h0);
        chk("rst_ext",   32'(bus.ext_wr), 32'h0);

        // CPU activity during CLEAR must be ignored; reset again at cycle 10.
        @(negedge clk); rst = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            bus.cpu_we = 1'b1; bus.cpu_reg = c[0]; bus.cpu_din = 8'h3F;
            bus.status_rd = c[1];
            @(posedge clk); #1;
            chk("clr_vaddr", 32'(bus.vaddr), 32'h0);
            chk("clr_pulse", 32'({bus.pal_wr_ack, bus.ext_wr}), 32'h0);
            chk("clr_ready", 32'(bus.ready), 32'h0);
            if (c < 10) @(negedge clk);
        end
        #1 rst = 1'b1;
        #1 chk("rst2_ready", 32'(bus.ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.cpu_we = 1'b1; bus.cpu_reg = 1'b1; bus.cpu_din = 8'h22;
        wait_ready(edges);
        drive_idle();
        chk("ready_edge", 32'(edges), 32'd32);
        chk("clr2_vaddr", 32'(bus.vaddr), 32'h0);
        chk("clr2_pulse", 32'({bus.pal_wr_ack, bus.ext_wr}), 32'h0);

        // Whole palette reads back as the clear value.
        for (int a = 0; a < 32; a++) begin
            bus.rd_addr = 5'(a);
            #1 chk($sformatf("clear_rd[%0d]", a), 32'(bus.rd_dout), 32'h0F);
        end

        // Table-driven register accesses, one cycle per record.
        foreach (vt[i]) begin
            @(negedge clk);
            bus.cpu_we = vt[i].we; bus.cpu_reg = vt[i].rg; bus.cpu_din = vt[i].din;
            bus.inc32 = vt[i].i32; bus.status_rd = vt[i].st; bus.rd_addr = vt[i].ra;
            @(posedge clk); #1;
            chk($sformatf("v%0d_vaddr", i), 32'(bus.vaddr), 32'(vt[i].e_va));
            chk($sformatf("v%0d_ack", i), 32'(bus.pal_wr_ack), 32'(vt[i].e_ack));
            chk($sformatf("v%0d_ext", i), 32'(bus.ext_wr), 32'(vt[i].e_ext));
            chk($sformatf("v%0d_rd", i), 32'(bus.rd_dout), 32'(vt[i].e_rd));
            chk($sformatf("v%0d_excl", i), 32'(bus.pal_wr_ack & bus.ext_wr), 32'h0);
        end

        // Reset in IDLE acts immediately and restarts the full clear.
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        #1;
        chk("idle_rst_vaddr", 32'(bus.vaddr), 32'h0);
        chk("idle_rst_ack",   32'(bus.pal_wr_ack), 32'h0);
        chk("idle_rst_ready", 32'(bus.ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        wait_ready(edges);
        chk("ready_edge3", 32'(edges), 32'd32);
        bus.rd_addr = 5'h00;
        #1 chk("reclear_rd0", 32'(bus.rd_dout), 32'h0F);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
